// File: rtl/btb_2bit_param.sv
// Branch target buffer: direct-mapped table with a 2-bit saturating predictor and a mispredict statistic.
// Lookup is zero-cycle from registered state; updates take effect at the next edge. No backpressure: one update per cycle is accepted.
module btb_2bit_param #(
  parameter int         ENTRIES   = 16,
  parameter logic [1:0] ALLOC_CTR = 2'b10,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc4,
  output logic             hit,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  input  logic             upd_en,
  input  logic [31:0]      upd_pc4,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             flush,
  output logic [CNT_W-1:0] mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];
  logic [CNT_W-1:0]   r_mispred_cnt;

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_u_idx;
  logic [TAG_W-1:0] w_u_tag;
  logic             w_u_hit;
  logic             w_u_pred;
  logic             w_mispred;
  logic             w_alloc;
  logic             w_train;

  assign w_idx       = pc4[IDX_W+1:2];
  assign w_tag       = pc4[31:IDX_W+2];
  assign hit         = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign pred_taken  = hit & r_ctr[w_idx][1];
  assign pred_target = hit ? r_target[w_idx] : 32'h0;

  // Update path has its own comparator so it never depends on the fetch address.
  assign w_u_idx   = upd_pc4[IDX_W+1:2];
  assign w_u_tag   = upd_pc4[31:IDX_W+2];
  assign w_u_hit   = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
  assign w_u_pred  = w_u_hit & r_ctr[w_u_idx][1];
  assign w_mispred = upd_en && (w_u_pred != upd_taken);
  assign w_alloc   = upd_en && !flush && !w_u_hit && upd_taken;
  assign w_train   = upd_en && !flush && w_u_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int i = 0; i < ENTRIES; i++) r_ctr[i] <= 2'b01;
    end else begin
      if (flush)        r_valid          <= '0;
      else if (w_alloc) r_valid[w_u_idx] <= 1'b1;

      if (w_alloc) begin
        r_ctr[w_u_idx] <= ALLOC_CTR;
      end else if (w_train) begin
        if (upd_taken) begin
          if (r_ctr[w_u_idx] != 2'b11) r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
        end else begin
          if (r_ctr[w_u_idx] != 2'b00) r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
        end
      end
    end
  end

  // Tag and target carry no reset; they are only observable behind a set valid bit.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_u_idx]    <= w_u_tag;
      r_target[w_u_idx] <= upd_target;
    end else if (w_train && upd_taken) begin
      r_target[w_u_idx] <= upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              r_mispred_cnt <= '0;
    else if (w_mispred && r_mispred_cnt != '1) r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
  end

  assign mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_btb_2bit_param.sv
// Directed bench for btb_2bit_param: default instance plus a CNT_W=2 instance for saturation.
module tb_btb_2bit_param;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc4;
  logic        upd_en, b_upd_en;
  logic [31:0] upd_pc4;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        flush;

  logic        hit, pred_taken;
  logic [31:0] pred_target;
  logic [15:0] mispred_cnt;
  logic        b_hit, b_pred_taken;
  logic [31:0] b_pred_target;
  logic [1:0]  b_mispred_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btb_2bit_param dut (
    .clk(clk), .rst_n(rst_n), .pc4(pc4), .hit(hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_en(upd_en), .upd_pc4(upd_pc4),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush(flush),
    .mispred_cnt(mispred_cnt)
  );

  btb_2bit_param #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .pc4(pc4), .hit(b_hit), .pred_taken(b_pred_taken),
    .pred_target(b_pred_target), .upd_en(b_upd_en), .upd_pc4(upd_pc4),
    .upd_taken(upd_taken), .upd_target(upd_target), .flush(flush),
    .mispred_cnt(b_mispred_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc4 = pc; upd_taken = tk; upd_target = tgt;
    tick();
    upd_en = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic h, input logic pt, input logic [31:0] tgt);
    pc4 = pc;
    #1;
    chk({tag, "_hit"}, {31'b0, hit}, {31'b0, h});
    chk({tag, "_pt"}, {31'b0, pred_taken}, {31'b0, pt});
    chk({tag, "_tgt"}, pred_target, tgt);
  endtask

  initial begin
    rst_n = 1'b0; pc4 = 32'h0; upd_en = 1'b0; b_upd_en = 1'b0;
    upd_pc4 = 32'h0; upd_taken = 1'b0; upd_target = 32'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    look("reset", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    chk("reset_cnt", {16'b0, mispred_cnt}, 32'd0);
    chk("reset_cnt_b", {30'b0, b_mispred_cnt}, 32'd0);

    // Allocation on a taken miss: mispredicted, ctr = 2.
    upd(32'h0000_1000, 1'b1, 32'h0000_2000);
    look("alloc", 32'h0000_1000, 1'b1, 1'b1, 32'h0000_2000);
    chk("alloc_cnt", {16'b0, mispred_cnt}, 32'd1);

    // Not-taken training: 2->1 (mispredict), 1->0, 0 stays 0.
    upd(32'h0000_1000, 1'b0, 32'hDEAD_BEEF);
    look("nt1", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    upd(32'h0000_1000, 1'b0, 32'h0);
    upd(32'h0000_1000, 1'b0, 32'h0);
    look("nt3", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000);
    chk("nt3_cnt", {16'b0, mispred_cnt}, 32'd2);
    // Saturated at 0: one taken brings ctr to 1, still predicting not-taken.
    upd(32'h0000_1000, 1'b1, 32'h0000_2004);
    look("sat0", 32'h0000_1000, 1'b1, 1'b0, 32'h0000_2004);
    chk("sat0_cnt", {16'b0, mispred_cnt}, 32'd3);

    // Not-taken miss: no allocation, no mispredict.
    upd(32'h0000_4444, 1'b0, 32'h0000_9999);
    look("ntmiss", 32'h0000_4444, 1'b0, 1'b0, 32'h0);
    chk("ntmiss_cnt", {16'b0, mispred_cnt}, 32'd3);

    // Aliasing: 0x1040 shares index 0 with 0x1000 and replaces it.
    upd(32'h0000_1040, 1'b1, 32'h0000_5000);
    look("alias_old", 32'h0000_1000, 1'b0, 1'b0, 32'h0);
    look("alias_new", 32'h0000_1040, 1'b1, 1'b1, 32'h0000_5000);
    chk("alias_cnt", {16'b0, mispred_cnt}, 32'd4);

    // Same-cycle lookup and allocate: pre-edge contents seen first.
    pc4 = 32'h0000_3000;
    upd_en = 1'b1; upd_pc4 = 32'h0000_3000; upd_taken = 1'b1; upd_target = 32'h0000_3300;
    #1 chk("same_pre_hit", {31'b0, hit}, 32'd0);
    tick();
    upd_en = 1'b0;
    look("same_post", 32'h0000_3000, 1'b1, 1'b1, 32'h0000_3300);
    chk("same_cnt", {16'b0, mispred_cnt}, 32'd5);

    // Flush beats a same-cycle taken update, which still counts as a mispredict.
    flush = 1'b1;
    upd(32'h0000_5008, 1'b1, 32'h0000_6000);
    flush = 1'b0;
    look("flush_old", 32'h0000_3000, 1'b0, 1'b0, 32'h0);
    look("flush_new", 32'h0000_5008, 1'b0, 1'b0, 32'h0);
    chk("flush_cnt", {16'b0, mispred_cnt}, 32'd6);

    // Saturation at 3 and target refresh on taken hits.
    upd(32'h0000_2000, 1'b1, 32'h0000_2100);
    upd(32'h0000_2000, 1'b1, 32'h0000_2222);
    upd(32'h0000_2000, 1'b1, 32'h0000_2222);
    upd(32'h0000_2000, 1'b0, 32'h0);
    look("sat3", 32'h0000_2000, 1'b1, 1'b1, 32'h0000_2222);
    chk("sat3_cnt", {16'b0, mispred_cnt}, 32'd8);

    // CNT_W=2 instance: taken misses at distinct indices each mispredict.
    upd_en = 1'b0; b_upd_en = 1'b1; upd_taken = 1'b1; upd_target = 32'h0000_0800;
    for (int k = 0; k < 5; k++) begin
      upd_pc4 = 32'h0000_0100 + 32'(k * 4);
      tick();
      if (k == 2) chk("b_cnt3", {30'b0, b_mispred_cnt}, 32'd3);
    end
    b_upd_en = 1'b0;
    chk("b_cnt_sat", {30'b0, b_mispred_cnt}, 32'd3);

    // Async reset pulse between edges.
    pc4 = 32'h0000_2000;
    #1 chk("prerst_hit", {31'b0, hit}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_hit", {31'b0, hit}, 32'd0);
    chk("rst_cnt", {16'b0, mispred_cnt}, 32'd0);
    chk("rst_cnt_b", {30'b0, b_mispred_cnt}, 32'd0);
    #1 rst_n = 1'b1;
    upd(32'h0000_2000, 1'b1, 32'h0000_7000);
    look("postrst", 32'h0000_2000, 1'b1, 1'b1, 32'h0000_7000);
    chk("postrst_cnt", {16'b0, mispred_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/btb_2bit_param.md
Name: btb_2bit_param

Overview:
- Parametrised branch target buffer with per-entry 2-bit saturating predictor.
- Successor of the 16-entry, 1-bit, tag/destination table.
- Fetch stage does a same-cycle lookup on pc4 and gets hit, predicted direction and target.
- Execute stage sends resolved outcome one update per cycle; block applies counter training, allocation and a saturating mispredict statistic.

Parameters:
- ENTRIES, 16, number of entries; power of 2, range 2..1024.
- IDX_W, $clog2(ENTRIES), index width; derived, not overridden.
- TAG_W, 30-IDX_W, tag width = pc[31:IDX_W+2].
- ALLOC_CTR, 2'b10, counter value written on allocation (weakly taken).
- CNT_W, 16, mispredict statistic counter width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- pc4  in  32  lookup address (word aligned; bits [1:0] ignored)
- hit  out  1  entry valid and tag equal for pc4
- pred_taken  out  1  hit & ctr[1]
- pred_target  out  32  stored target when hit, else 32'h0
- upd_en  in  1  resolved branch update strobe
- upd_pc4  in  32  address of resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target
- flush  in  1  invalidate all entries
- mispred_cnt  out  CNT_W  saturating count of updates whose table prediction differed from upd_taken

Behaviour:
- Storage per entry: valid, tag[TAG_W-1:0], ctr[1:0], target[31:0].
- Index = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2].
- Reset (rst_n low, async):
  - all valid = 0, all ctr = 2'b01, mispred_cnt = 0.
  - tag/target are not reset.
  - Outputs during and after reset: hit = 0, pred_taken = 0, pred_target = 0.
- Lookup is combinational from registered state (zero-cycle latency).
  - hit = valid[i] && tag[i] == pc4 tag.
  - When hit = 0, pred_taken and pred_target are forced to 0.
- Update is evaluated on the clk rising edge when upd_en = 1. Let u_hit = match for upd_pc4 using pre-edge state.
  - u_hit & upd_taken: ctr saturating increment (3 stays 3); target <= upd_target.
  - u_hit & !upd_taken: ctr saturating decrement (0 stays 0); target unchanged.
  - !u_hit & upd_taken: allocate (replace any occupant) with valid = 1, tag, target = upd_target, ctr = ALLOC_CTR.
  - !u_hit & !upd_taken: no table change.
- Mispredict statistic:
  - table_pred = u_hit & ctr[1] (pre-edge).
  - If upd_en and table_pred != upd_taken, mispred_cnt increments.
  - Saturates at all-ones; never wraps.
- flush: on the edge, clears all valid bits; ctr/tag/target untouched.
  - flush beats a same-cycle upd_en: no allocation, no ctr change.
  - mispred_cnt still counts that update.
- Same-cycle lookup and update to the same index: lookup returns pre-edge contents. The update is visible the cycle after the edge.
- The update path uses only its own comparison and never depends on pc4.
- Reset asserted mid-operation overrides any pending update or flush; the first edge after rst_n rises behaves as normal.
- X on upd_* while upd_en = 0 has no effect.

Test Plan:
- Reset, then pc4 = 32'h0000_1000 -> hit = 0, pred_taken = 0, pred_target = 0, mispred_cnt = 0.
- Update pc4 = 32'h0000_1000, taken, target = 32'h0000_2000; next cycle lookup same pc4 -> hit = 1, pred_taken = 1, pred_target = 32'h0000_2000, mispred_cnt = 1.
- Two not-taken updates to that entry -> ctr 2→1→0; pred_taken = 0 with hit = 1. Third not-taken update keeps ctr = 0; mispred_cnt = 2, since only the first not-taken update mispredicted.
- Aliasing (ENTRIES = 16): allocate 32'h0000_1000, then taken update to 32'h0000_1040 (same index, different tag) -> 0x1000 misses, 0x1040 hits with ctr = 2.
- Same-cycle lookup and allocate of 32'h0000_3000 -> hit = 0 that cycle, hit = 1 next cycle. Flush with simultaneous taken upd_en -> all lookups miss and no allocation.
- CNT_W = 2: five mispredicting updates -> mispred_cnt sticks at 3. Async reset pulse between clock edges -> mispred_cnt = 0 immediately and hit = 0.
